// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants and types for the systolic skew feeder and the array it drives.
package systolic_pkg;

  localparam int N_DEF     = 3;
  localparam int W_DEF     = 5;
  localparam int DRAIN_DEF = 4;

  // Width of one array lane (one matrix element).
  localparam int LANE_W = W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/systolic_skew_feeder.sv
// Captures an A/B matrix pair and streams them into an N x N systolic array
// with the diagonal skew the array needs: row i of A is delayed by i beats,
// column j of B is delayed by j beats. After the 2N-1 feed beats the block
// stays busy for DRAIN cycles while the array finishes, then pulses done.
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both 1. in_ready is high only in IDLE and depends on state alone, so
// there is no combinational path from in_valid to in_ready.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int DRAIN = DRAIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic [N*W-1:0]   a_row,
  output logic [N*W-1:0]   b_col,
  output logic             feed_valid,
  output logic             acc_clr,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int TW = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
  localparam logic [DW-1:0] D_LAST = DW'((DRAIN > 0) ? DRAIN-1 : 0);

  state_t             state;
  state_t             state_nxt;
  logic [TW-1:0]      t;
  logic [DW-1:0]      dcnt;
  logic [N*N*W-1:0]   a_reg;
  logic [N*N*W-1:0]   b_reg;
  logic               take;
  logic               feeding;

  assign take    = (state == ST_IDLE) && in_valid;
  assign feeding = (state == ST_FEED);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> FEED on transfer, FEED -> DRAIN/IDLE after the
  // last beat, DRAIN -> IDLE after the last drain cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_FEED;
      ST_FEED:  if (t == T_LAST) state_nxt = (DRAIN > 0) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (dcnt == D_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Beat/drain counters and matrix capture; matrices only load on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      t     <= '0;
      dcnt  <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else if (take) begin
      a_reg <= a_flat;
      b_reg <= b_flat;
      t     <= '0;
      dcnt  <= '0;
    end else if (feeding) begin
      t    <= (t == T_LAST) ? '0 : t + 1'b1;
      dcnt <= '0;
    end else if (state == ST_DRAIN) begin
      dcnt <= (dcnt == D_LAST) ? '0 : dcnt + 1'b1;
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign feed_valid = feeding;
  assign acc_clr    = feeding && (t == '0);
  assign state_dbg  = state;

  generate
    if (DRAIN > 0) begin : g_done_drain
      assign done = (state == ST_DRAIN) && (dcnt == D_LAST);
    end else begin : g_done_feed
      assign done = feeding && (t == T_LAST);
    end
  endgenerate

  // Skew: lane i of A shows A[i][t-i]; the extra top bit makes t<i wrap to a
  // value >= N so a single range compare rejects it.
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [TW:0] a_c;
      logic [TW:0] a_cs;
      logic        a_hit;
      logic [TW:0] b_r;
      logic [TW:0] b_rs;
      logic        b_hit;

      assign a_c   = {1'b0, t} - (TW+1)'(i);
      assign a_hit = feeding && (a_c < (TW+1)'(N));
      assign a_cs  = a_hit ? a_c : '0;
      assign a_row[i*W +: W] = a_hit ? a_reg[(i*N + int'(a_cs))*W +: W] : '0;

      assign b_r   = {1'b0, t} - (TW+1)'(i);
      assign b_hit = feeding && (b_r < (TW+1)'(N));
      assign b_rs  = b_hit ? b_r : '0;
      assign b_col[i*W +: W] = b_hit ? b_reg[(int'(b_rs)*N + i)*W +: W] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a cycle-count model of the feeder kept next
// to the DUT, a per-cycle compare on the falling edge, and directed scenarios
// with hand-computed lane values.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int N      = 3;
  localparam int W      = 5;
  localparam int DRAIN  = 4;
  localparam int FEEDS  = 2*N-1;
  localparam int DONE_S = FEEDS-1+DRAIN;
  localparam int IDLE_S = FEEDS+DRAIN;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*N*W-1:0] a_flat;
  logic [N*N*W-1:0] b_flat;
  logic [N*W-1:0]   a_row;
  logic [N*W-1:0]   b_col;
  logic             feed_valid;
  logic             acc_clr;
  logic             done;
  logic [1:0]       state_dbg;

  systolic_skew_feeder #(.N(N), .W(W), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_flat(a_flat), .b_flat(b_flat), .a_row(a_row), .b_col(b_col),
    .feed_valid(feed_valid), .acc_clr(acc_clr), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int clr_q[$];
  int done_q[$];
  int fv_cnt  = 0;
  int clr_cnt = 0;
  bit mon_en  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N*N*W-1:0] pack(input int base, input int stp);
    logic [N*N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N*N; k++) v[k*W +: W] = W'(base + stp*k);
    return v;
  endfunction

  // Model: cycles elapsed since the transfer edge decide everything.
  // m_s = 0 is the first beat; beats run 0..FEEDS-1, done at DONE_S, idle at IDLE_S.
  bit           m_busy = 0;
  int           m_s    = 0;
  logic [W-1:0] ma[N][N];
  logic [W-1:0] mb[N][N];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_s++;
      if (m_s == IDLE_S) m_busy = 0;
    end else if (in_valid) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = a_flat[(r*N+c)*W +: W];
          mb[r][c] = b_flat[(r*N+c)*W +: W];
        end
      m_busy = 1;
      m_s    = 0;
    end
  end

  // Per-cycle compare against the model, plus event logging.
  logic [N*W-1:0] ea;
  logic [N*W-1:0] eb;
  bit             efeed;
  logic [1:0]     est;
  always @(negedge clk) begin
    if (mon_en) begin
      efeed = m_busy && (m_s < FEEDS);
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        if (efeed && m_s >= i && m_s - i < N) begin
          ea[i*W +: W] = ma[i][m_s-i];
          eb[i*W +: W] = mb[m_s-i][i];
        end
      end
      est = !m_busy ? ST_IDLE : (efeed ? ST_FEED : ST_DRAIN);
      check("in_ready",   64'(in_ready),   64'(!m_busy));
      check("feed_valid", 64'(feed_valid), 64'(efeed));
      check("acc_clr",    64'(acc_clr),    64'(efeed && m_s == 0));
      check("done",       64'(done),       64'(m_busy && m_s == DONE_S));
      check("a_row",      64'(a_row),      64'(ea));
      check("b_col",      64'(b_col),      64'(eb));
      check("state",      64'(state_dbg),  64'(est));
      if (feed_valid) fv_cnt++;
      if (acc_clr) begin clr_cnt++; clr_q.push_back(cyc); end
      if (done) done_q.push_back(cyc);
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin step(1); n++; end
    check("idle_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic xfer(input logic [N*N*W-1:0] a, input logic [N*N*W-1:0] b);
    wait_idle();
    in_valid = 1'b1;
    a_flat   = a;
    b_flat   = b;
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a_flat   = '0;
    b_flat   = '0;
    step(2);
    mon_en = 1;
    // Reset state.
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_a_row",    64'(a_row),    64'd0);
    check("rst_b_col",    64'(b_col),    64'd0);
    check("rst_fv",       64'(feed_valid), 64'd0);
    check("rst_clr",      64'(acc_clr),  64'd0);
    check("rst_done",     64'(done),     64'd0);
    rst = 1'b0;
    step(1);

    // All A=4, all B=1.
    fv_cnt = 0; clr_cnt = 0;
    xfer(pack(4, 0), pack(1, 0));
    check("s1_t0_a",   64'(a_row),   64'(15'd4));
    check("s1_t0_b",   64'(b_col),   64'(15'd1));
    check("s1_t0_clr", 64'(acc_clr), 64'd1);
    step(2);
    check("s1_t2_a", 64'(a_row), 64'({5'd4, 5'd4, 5'd4}));
    check("s1_t2_b", 64'(b_col), 64'({5'd1, 5'd1, 5'd1}));
    step(2);
    check("s1_t4_a", 64'(a_row), 64'({5'd4, 10'd0}));
    check("s1_t4_b", 64'(b_col), 64'({5'd1, 10'd0}));
    wait_idle();
    check("s1_fv_cnt",  64'(fv_cnt),  64'd5);
    check("s1_clr_cnt", 64'(clr_cnt), 64'd1);

    // A = 1..9, B = 9..1, row-major.
    xfer(pack(1, 1), pack(9, -1));
    step(1);
    exp_q.push_back(5'd2); exp_q.push_back(5'd4);
    exp_q.push_back(5'd6); exp_q.push_back(5'd8);
    check("s2_t1_a0", 64'(a_row[0 +: W]), 64'(exp_q.pop_front()));
    check("s2_t1_a1", 64'(a_row[W +: W]), 64'(exp_q.pop_front()));
    check("s2_t1_b0", 64'(b_col[0 +: W]), 64'(exp_q.pop_front()));
    check("s2_t1_b1", 64'(b_col[W +: W]), 64'(exp_q.pop_front()));
    step(3);
    check("s2_t4_a2", 64'(a_row[2*W +: W]), 64'd9);
    check("s2_t4_b2", 64'(b_col[2*W +: W]), 64'd1);
    wait_idle();

    // Reset at t=2 aborts with no done pulse; a new transfer restarts cleanly.
    xfer(pack(1, 1), pack(1, 1));
    step(2);
    done_q.delete();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s4_in_ready", 64'(in_ready),   64'd1);
    check("s4_fv",       64'(feed_valid), 64'd0);
    check("s4_a_row",    64'(a_row),      64'd0);
    check("s4_b_col",    64'(b_col),      64'd0);
    check("s4_done",     64'(done),       64'd0);
    step(12);
    check("s4_no_done", 64'(done_q.size()), 64'd0);
    xfer(pack(2, 0), pack(3, 0));
    check("s4_new_a",   64'(a_row),   64'(15'd2));
    check("s4_new_b",   64'(b_col),   64'(15'd3));
    check("s4_new_clr", 64'(acc_clr), 64'd1);
    wait_idle();

    // Inputs changed mid-feed must not leak into the stream.
    xfer(pack(5, 0), pack(6, 0));
    a_flat   = pack(7, 0);
    b_flat   = pack(8, 0);
    in_valid = 1'b0;
    step(2);
    check("s5_a", 64'(a_row), 64'({5'd5, 5'd5, 5'd5}));
    check("s5_b", 64'(b_col), 64'({5'd6, 5'd6, 5'd6}));
    wait_idle();

    // Back-to-back: in_valid held high gives one transfer every 10 cycles.
    clr_q.delete();
    done_q.delete();
    a_flat   = pack(3, 1);
    b_flat   = pack(2, 1);
    in_valid = 1'b1;
    step(32);
    in_valid = 1'b0;
    wait_idle();
    check("s3_xfers", 64'(clr_q.size() >= 3), 64'd1);
    check("s3_dones", 64'(done_q.size()), 64'(clr_q.size()));
    for (int k = 1; k < clr_q.size(); k++)
      check("s3_period", 64'(clr_q[k] - clr_q[k-1]), 64'd10);
    for (int k = 0; k < clr_q.size() && k < done_q.size(); k++)
      check("s3_done_lat", 64'(done_q[k] - clr_q[k]), 64'd8);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
